// File: rtl/uart_rx_frame_check.sv
// Serial-domain UART frame checker: start, data (LSB first), optional parity, 1-2 stop bits.
// Define UART_RX_ERR_CNT_EN to build the saturating parity/stop error counters.
module uart_rx_frame_check #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bit_vld,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP2,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  frame_done,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int unsigned BCW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_e;

    state_e                state_q;
    logic [BCW-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_q;
    logic                  par_bad_q;
    logic                  par_en_q;
    logic [1:0]            par_typ_q;
    logic                  stop2_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  frame_done_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  busy_q;

    logic                  frame_end_c;
    logic                  stp_bad_c;
    logic                  par_exp_c;

    // Frame-end decode and expected parity bit for the latched mode
    always_comb begin
        frame_end_c = 1'b0;
        stp_bad_c   = 1'b0;
        if (bit_vld) begin
            case (state_q)
                ST_STOP1: begin
                    if (!sampled_bit) begin
                        frame_end_c = 1'b1;
                        stp_bad_c   = 1'b1;
                    end else if (!stop2_q) begin
                        frame_end_c = 1'b1;
                    end
                end
                ST_STOP2: begin
                    frame_end_c = 1'b1;
                    stp_bad_c   = !sampled_bit;
                end
                default: ;
            endcase
        end
        case (par_typ_q)
            2'b00:   par_exp_c = par_q;
            2'b01:   par_exp_c = !par_q;
            2'b10:   par_exp_c = 1'b1;
            default: par_exp_c = 1'b0;
        endcase
    end

    // Frame state machine; per-frame results publish only at frame end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            par_bad_q    <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 2'b00;
            stop2_q      <= 1'b0;
            p_data_q     <= '0;
            frame_done_q <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            data_valid_q <= 1'b0;
            if (bit_vld) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!sampled_bit) begin
                            par_en_q  <= PAR_EN;
                            par_typ_q <= PAR_TYP;
                            stop2_q   <= STOP2;
                            cnt_q     <= '0;
                            par_q     <= 1'b0;
                            par_bad_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        // Shifting in from the top leaves the first bit at [0]
                        shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                        par_q   <= par_q ^ sampled_bit;
                        cnt_q   <= cnt_q + BCW'(1);
                        if (cnt_q == BCW'(DATA_WIDTH - 1)) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP1;
                        end
                    end
                    ST_PARITY: begin
                        par_bad_q <= (sampled_bit != par_exp_c);
                        state_q   <= ST_STOP1;
                    end
                    ST_STOP1: begin
                        if (sampled_bit && stop2_q) begin
                            state_q <= ST_STOP2;
                        end
                    end
                    default: ;
                endcase
            end
            if (frame_end_c) begin
                state_q      <= ST_IDLE;
                busy_q       <= 1'b0;
                frame_done_q <= 1'b1;
                data_valid_q <= !par_bad_q && !stp_bad_c;
                par_err_q    <= par_bad_q;
                stp_err_q    <= stp_bad_c;
                p_data_q     <= shift_q;
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign frame_done = frame_done_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] par_cnt_q;
    logic [CNT_WIDTH-1:0] stp_cnt_q;

    // Saturating counters; a clear beats a same-cycle increment
    always_ff @(posedge CLK) begin
        if (RST || clr_cnt) begin
            par_cnt_q <= '0;
            stp_cnt_q <= '0;
        end else if (frame_end_c) begin
            if (par_bad_q && (par_cnt_q != '1)) begin
                par_cnt_q <= par_cnt_q + CNT_WIDTH'(1);
            end
            if (stp_bad_c && (stp_cnt_q != '1)) begin
                stp_cnt_q <= stp_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign par_err_cnt = par_cnt_q;
    assign stp_err_cnt = stp_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign par_err_cnt    = '0;
    assign stp_err_cnt    = '0;
`endif

endmodule

// File: doc/uart_rx_frame_check.md
# uart_rx_frame_check

Serial-domain frame checker for the UART receiver, successor to the single-shot parity checker. It consumes one sampled bit per strobe from the receiver's sampler and tracks the whole frame with an internal state machine: start, DATA_WIDTH data bits (LSB first), optional parity, and one or two stop bits. It computes parity on the fly in one of four modes, checks the stop bits, and delivers the parallel word with per-frame error flags and optional saturating error counters.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..9
- CNT_WIDTH, 8, width of each error counter
- CLK  in  1  receiver clock
- RST  in  1  synchronous, active-high reset
- bit_vld  in  1  one-cycle strobe; sampled_bit is valid this cycle
- sampled_bit  in  1  sampled line value
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
- STOP2  in  1  1 = two stop bits
- clr_cnt  in  1  clears both error counters
- P_DATA  out  DATA_WIDTH  last received word
- frame_done  out  1  one-cycle pulse per completed or aborted frame
- data_valid  out  1  one-cycle pulse; frame completed with no error
- par_err  out  1  parity error, last frame
- stp_err  out  1  stop-bit error, last frame
- busy  out  1  high while state != IDLE
- par_err_cnt  out  CNT_WIDTH  saturating parity-error count
- stp_err_cnt  out  CNT_WIDTH  saturating stop-error count

## Operation
- States: IDLE, DATA, PARITY, STOP1, STOP2. Transitions occur only on cycles with bit_vld=1.
- IDLE: bit_vld with sampled_bit=1 is ignored. bit_vld with sampled_bit=0 is the start bit. On it, latch PAR_EN, PAR_TYP and STOP2, clear the bit counter and the running parity, and go to DATA. Configuration changes mid-frame have no effect.
- DATA: shift the bit into P_DATA position [count] (LSB first) and XOR it into the running parity. After DATA_WIDTH bits, go to PARITY if PAR_EN is set, else to STOP1.
- PARITY: the expected bit is running parity for even, its inverse for odd, 1 for mark, 0 for space. par_err is set when the received bit differs from the expected bit. Go to STOP1.
- STOP1: a bit of 0 sets stp_err and aborts the frame to IDLE without waiting for a second stop bit. A bit of 1 ends the frame, or goes to STOP2 if the latched STOP2 is set.
- STOP2: a bit of 0 sets stp_err. In either case, end the frame and go to IDLE.
- Frame end:
  - frame_done pulses.
  - data_valid pulses only if par_err=0 and stp_err=0.
  - P_DATA, par_err and stp_err hold until the next frame end.
  - On an error-free frame, par_err and stp_err are cleared.
- Counters: increment on frame end when the matching flag is set, and saturate at 2^CNT_WIDTH-1. If clr_cnt and an increment occur in the same cycle, clear wins and the increment is lost.

## Timing
- All outputs are registered.
- Reset values:
  - P_DATA = 0
  - all flags and pulses = 0
  - busy = 0
  - both counters = 0
  - state = IDLE
- frame_done, data_valid, par_err, stp_err and P_DATA update in the cycle after the bit_vld of the final frame bit (last stop bit, or the failing STOP1 bit).
- busy rises the cycle after the start-bit strobe and falls together with the frame_done pulse.
- bit_vld may be asserted on consecutive cycles. A start bit is accepted on the cycle after frame_done; no dead cycle is required.
- RST mid-frame discards the partial word, returns to IDLE, and clears all outputs including the counters.

## Configuration
- UART_RX_ERR_CNT_EN defined: par_err_cnt and stp_err_cnt are implemented as described above.
- UART_RX_ERR_CNT_EN undefined: the counter logic is removed. Both counter outputs are tied to 0 and clr_cnt is ignored. All other behaviour is unchanged.

## Test plan
- DATA_WIDTH=8, PAR_EN=1, PAR_TYP=00. Send start, data 0xA5 LSB first, parity 0, stop 1 -> P_DATA=0xA5, data_valid=1, frame_done=1, par_err=0.
- Same frame with parity bit 1 -> par_err=1, data_valid=0, frame_done=1, par_err_cnt=1. Then send an error-free frame -> par_err returns to 0.
- PAR_EN=0, STOP2=1, data 0x3C, stop bits 1 then 0 -> stp_err=1, stp_err_cnt=1. A second variant with first stop bit 0 aborts after that bit, and busy falls with frame_done.
- PAR_TYP=10 (mark) with parity bit 0, data 0x00 -> par_err=1. PAR_TYP=11 (space) with parity bit 0 -> par_err=0. Also change PAR_TYP mid-frame and check it is ignored.
- CNT_WIDTH=2: four parity-error frames -> par_err_cnt=3 (saturated). clr_cnt coincident with a fifth error frame end -> par_err_cnt=0.
- DATA_WIDTH=5 with back-to-back bit_vld every cycle. Assert RST after the third data bit -> all outputs 0 and state IDLE. The next frame, data 0x15, is received correctly.
